// File: rtl/ready_valid_rx_buffer.sv
// ready_valid_rx_buffer
// ---------------------------------------------------------------------------
// Receiving end of a byte-wide ready/valid link. Bytes accepted from the
// upstream transmitter are queued in a first-word-fall-through FIFO and
// offered to a local consumer on a second ready/valid port. A burst/stall
// throttle can periodically drop ready to exercise the transmitter's
// backpressure handling, and upstream protocol violations are flagged.
//
// Optional build macro: READY_VALID_RX_STATS_EN adds the acc_cnt/bp_cnt
// statistics outputs. Without it those ports do not exist.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   valid        in   upstream byte valid
//   data         in   upstream byte
//   ready        out  upstream ready (registered state only)
//   m_valid      out  consumer byte valid (FIFO not empty)
//   m_data       out  consumer byte (head of FIFO, 0 when empty)
//   m_ready      in   consumer ready
//   throttle_en  in   enable burst/stall backpressure
//   burst_len    in   handshakes per burst (0 disables throttling)
//   stall_len    in   ready-low cycles after a burst (0 disables throttling)
//   level        out  FIFO occupancy 0..DEPTH
//   protocol_err out  sticky upstream violation flag
//   clr_err      in   synchronous clear of protocol_err (and statistics)
//   acc_cnt      out  [stats build] saturating handshake count
//   bp_cnt       out  [stats build] saturating valid-while-not-ready count
// ---------------------------------------------------------------------------
module ready_valid_rx_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    input  logic              throttle_en,
    input  logic [3:0]        burst_len,
    input  logic [3:0]        stall_len,
    output logic [PTR_W:0]    level,
    output logic              protocol_err,
    input  logic              clr_err
`ifdef READY_VALID_RX_STATS_EN
    ,
    output logic [15:0]       acc_cnt,
    output logic [15:0]       bp_cnt
`endif
);

    localparam logic [0:0]     ST_ACCEPT  = 1'b0;
    localparam logic [0:0]     ST_STALL   = 1'b1;
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    level_reg;
    logic [0:0]        state_reg, state_next;
    logic [3:0]        hs_cnt_reg, hs_cnt_next;
    logic [3:0]        st_cnt_reg, st_cnt_next;
    // Low from reset until the first edge after rst_n releases, so ready
    // cannot rise in the same cycle the reset is removed.
    logic              live_reg;
    logic              err_reg, err_next;
    logic              prev_valid_reg;
    logic              prev_ready_reg;
    logic [DATA_W-1:0] prev_data_reg;
    logic              push;
    logic              pop;
    logic              throttle_on;
    logic              violation;

    assign ready   = live_reg && (state_reg == ST_ACCEPT) && (level_reg != FULL_LEVEL);
    assign m_valid = (level_reg != '0);
    // Memory is never reset, so the head is masked while empty.
    assign m_data  = m_valid ? mem[rd_ptr_reg] : '0;
    assign level   = level_reg;
    assign protocol_err = err_reg;

    assign push = valid && ready;
    assign pop  = m_valid && m_ready;

    // ---------------- FIFO storage and pointers ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            live_reg   <= 1'b0;
        end else begin
            live_reg <= 1'b1;
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                level_reg <= level_reg + (PTR_W + 1)'(1);
            end else if (pop && !push) begin
                level_reg <= level_reg - (PTR_W + 1)'(1);
            end
        end
    end

    // ---------------- burst/stall throttle ----------------
    assign throttle_on = throttle_en && (burst_len != 4'd0) && (stall_len != 4'd0);

    always_comb begin
        state_next  = state_reg;
        hs_cnt_next = hs_cnt_reg;
        st_cnt_next = st_cnt_reg;
        if (!throttle_on) begin
            state_next  = ST_ACCEPT;
            hs_cnt_next = 4'd0;
            st_cnt_next = 4'd0;
        end else if (state_reg == ST_ACCEPT) begin
            if (push) begin
                // >= rather than == so a burst_len lowered mid-burst still
                // ends the burst on the next handshake.
                if (({1'b0, hs_cnt_reg} + 5'd1) >= {1'b0, burst_len}) begin
                    state_next  = ST_STALL;
                    hs_cnt_next = 4'd0;
                    st_cnt_next = stall_len;
                end else begin
                    hs_cnt_next = hs_cnt_reg + 4'd1;
                end
            end
        end else begin
            if (st_cnt_reg <= 4'd1) begin
                state_next  = ST_ACCEPT;
                st_cnt_next = 4'd0;
            end else begin
                st_cnt_next = st_cnt_reg - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_ACCEPT;
            hs_cnt_reg <= 4'd0;
            st_cnt_reg <= 4'd0;
        end else begin
            state_reg  <= state_next;
            hs_cnt_reg <= hs_cnt_next;
            st_cnt_reg <= st_cnt_next;
        end
    end

    // ---------------- protocol checking ----------------
    // A byte offered while ready was low must stay offered and unchanged.
    assign violation = prev_valid_reg && !prev_ready_reg &&
                       (!valid || (data != prev_data_reg));

    always_comb begin
        err_next = err_reg;
        if (violation) begin
            err_next = 1'b1;
        end else if (clr_err) begin
            err_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg        <= 1'b0;
            prev_valid_reg <= 1'b0;
            prev_ready_reg <= 1'b0;
            prev_data_reg  <= '0;
        end else begin
            err_reg        <= err_next;
            prev_valid_reg <= valid;
            prev_ready_reg <= ready;
            prev_data_reg  <= data;
        end
    end

`ifdef READY_VALID_RX_STATS_EN
    // ---------------- statistics ----------------
    logic [15:0] acc_cnt_reg;
    logic [15:0] bp_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_reg <= 16'd0;
            bp_cnt_reg  <= 16'd0;
        end else if (clr_err) begin
            acc_cnt_reg <= 16'd0;
            bp_cnt_reg  <= 16'd0;
        end else begin
            if (push && (acc_cnt_reg != 16'hFFFF)) begin
                acc_cnt_reg <= acc_cnt_reg + 16'd1;
            end
            if (valid && !ready && (bp_cnt_reg != 16'hFFFF)) begin
                bp_cnt_reg <= bp_cnt_reg + 16'd1;
            end
        end
    end

    assign acc_cnt = acc_cnt_reg;
    assign bp_cnt  = bp_cnt_reg;
`endif

endmodule
